// File: rtl/mio_arb_pkg.sv
// Shared definitions for the two-master memory/IO bus arbiter:
// FSM state encoding, one-hot grant encodings and master indices.
package mio_arb_pkg;

  // Arbiter FSM states; the encoding is visible on state_out.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_BUSY_CPU = 2'b01,
    ST_BUSY_DMA = 2'b10,
    ST_DONE     = 2'b11
  } state_t;

  // One-hot bus owner encodings driven on grant.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_DMA  = 2'b10;

  // Master indices, used by the last-served pointer.
  localparam logic MST_CPU = 1'b0;
  localparam logic MST_DMA = 1'b1;

  // True for either BUSY state (slave access in progress).
  function automatic logic is_busy(input state_t s);
    return (s == ST_BUSY_CPU) || (s == ST_BUSY_DMA);
  endfunction

endpackage

// File: rtl/mio_timeout_cnt.sv
// Cycle counter bounding how long the arbiter waits for a slave ack.
// expired is high during the TIMEOUT-th enabled cycle after a clear,
// so the caller can leave BUSY at the end of exactly that cycle.
module mio_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  assign expired = (count == 8'(TIMEOUT - 1));

  // Count enabled cycles; hold once expired so the value never wraps.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 8'd0;
    end else if (enable && !expired) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Two-master (CPU, DMA) arbiter for the shared memory/IO bus.
// The winning request is latched into the mem_* registers, the slave is
// strobed until mem_ack or timeout, then the owner gets registered read
// data and a one-cycle ready pulse.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// otherwise the CPU always wins simultaneous requests.
//
// Handshake: a master raises <m>_req with we/addr/wdata valid and holds all
// of them until <m>_ready pulses for one cycle; ready is the only
// completion indication and read data is valid on <m>_rdata from that
// cycle on. Toward the slave, mem_en is held with stable we/addr/wdata
// until mem_ack (which may come in the first mem_en cycle) or timeout.
module mio_bus_arbiter
  import mio_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        grant,
  output logic              bus_err,
  output logic [1:0]        state_out
);

  state_t state;
  state_t state_next;
  logic   any_req;
  logic   pick_dma;
  logic   busy;
  logic   expired;

  assign any_req = cpu_req || dma_req;
  assign busy    = is_busy(state);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_served;

  // Tie goes to the master not served last; a lone requester always wins.
  assign pick_dma = dma_req && (!cpu_req || (last_served == MST_CPU));

  // Remember which master entered BUSY most recently.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_served <= MST_DMA;
    end else if (state == ST_IDLE && any_req) begin
      last_served <= pick_dma ? MST_DMA : MST_CPU;
    end
  end
`else
  // Fixed priority: the DMA only wins when the CPU is not requesting.
  assign pick_dma = dma_req && !cpu_req;
`endif

  // Bounds the BUSY period; cleared while idle so each access starts at 0.
  mio_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == ST_IDLE),
    .enable  (busy),
    .expired (expired)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; an ack in the expiring cycle still ends in DONE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_next = pick_dma ? ST_BUSY_DMA : ST_BUSY_CPU;
        end
      end
      ST_BUSY_CPU, ST_BUSY_DMA: begin
        if (mem_ack || expired) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Request latch, owner tracking, read-data capture and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      grant     <= GNT_NONE;
      bus_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            mem_we    <= pick_dma ? dma_we    : cpu_we;
            mem_addr  <= pick_dma ? dma_addr  : cpu_addr;
            mem_wdata <= pick_dma ? dma_wdata : cpu_wdata;
            grant     <= pick_dma ? GNT_DMA   : GNT_CPU;
          end
        end
        ST_BUSY_CPU: begin
          if (mem_ack) begin
            if (!mem_we) begin
              cpu_rdata <= mem_rdata;
            end
          end else if (expired) begin
            bus_err   <= 1'b1;
            cpu_rdata <= '0;
          end
        end
        ST_BUSY_DMA: begin
          if (mem_ack) begin
            if (!mem_we) begin
              dma_rdata <= mem_rdata;
            end
          end else if (expired) begin
            bus_err   <= 1'b1;
            dma_rdata <= '0;
          end
        end
        ST_DONE: begin
          grant <= GNT_NONE;
        end
        default: begin
          grant <= GNT_NONE;
        end
      endcase
    end
  end

  // Outputs decoded from state and registers only.
  assign mem_en    = busy;
  assign cpu_ready = (state == ST_DONE) && (grant == GNT_CPU);
  assign dma_ready = (state == ST_DONE) && (grant == GNT_DMA);
  assign state_out = state;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed self-checking bench for mio_bus_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mio_bus_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we, dma_req, dma_we;
  logic [ADDR_W-1:0] cpu_addr, dma_addr;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata;
  logic              cpu_ready, dma_ready;
  logic              mem_en, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [1:0]        grant, state_out;
  logic              bus_err;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_cpu_rdata = '0;
  logic [DATA_W-1:0] exp_dma_rdata = '0;

  mio_bus_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_rdata (dma_rdata),
    .dma_ready (dma_ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .grant     (grant),
    .bus_err   (bus_err),
    .state_out (state_out)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    tick(); tick(); tick();
    checks++; if (state_out !== 2'b00) begin errors++; $display("FAIL rst_state got %b exp 00", state_out); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got %b exp 0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
    checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin errors++; $display("FAIL rst_mem_bus got %h/%h exp 0/0", mem_addr, mem_wdata); end
    checks++; if (cpu_rdata !== '0 || dma_rdata !== '0) begin errors++; $display("FAIL rst_rdata got %h/%h exp 0/0", cpu_rdata, dma_rdata); end
    checks++; if (cpu_ready !== 1'b0 || dma_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b%b exp 00", cpu_ready, dma_ready); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b exp 00", grant); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err got %b exp 0", bus_err); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0010; cpu_wdata = 32'hDEAD_0000;
    tick(); // cycle 1
    checks++; if (state_out !== 2'b01) begin errors++; $display("FAIL cpurd_state1 got %b exp 01", state_out); end
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL cpurd_en_we got %b%b exp 10", mem_en, mem_we); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL cpurd_addr got %h exp 00000010", mem_addr); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL cpurd_grant1 got %b exp 01", grant); end
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL cpurd_early_ready got %b exp 0", cpu_ready); end
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    tick(); // cycle 2
    mem_ack = 0; mem_rdata = '0;
    exp_cpu_rdata = 32'h1234_5678;
    checks++; if (cpu_ready !== 1'b1 || dma_ready !== 1'b0) begin errors++; $display("FAIL cpurd_ready got %b%b exp 10", cpu_ready, dma_ready); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL cpurd_en_done got %b exp 0", mem_en); end
    checks++; if (cpu_rdata !== exp_cpu_rdata) begin errors++; $display("FAIL cpurd_rdata got %h exp %h", cpu_rdata, exp_cpu_rdata); end
    checks++; if (grant !== 2'b01 || state_out !== 2'b11) begin errors++; $display("FAIL cpurd_done got g%b s%b exp g01 s11", grant, state_out); end
    cpu_req = 0;
    tick(); // cycle 3
    checks++; if (state_out !== 2'b00 || grant !== 2'b00 || cpu_ready !== 1'b0) begin
      errors++; $display("FAIL cpurd_idle got s%b g%b r%b exp s00 g00 r0", state_out, grant, cpu_ready); end
  endtask

  task automatic test_dma_write_wait();
    dma_req = 1; dma_we = 1; dma_addr = 32'h0000_0100; dma_wdata = 32'hA5A5_A5A5;
    tick(); // cycle 1
    for (int i = 1; i <= 4; i++) begin
      checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL dmawr_en_we c%0d got %b%b exp 11", i, mem_en, mem_we); end
      checks++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hA5A5_A5A5) begin
        errors++; $display("FAIL dmawr_stable c%0d got %h/%h exp 00000100/a5a5a5a5", i, mem_addr, mem_wdata); end
      checks++; if (grant !== 2'b10 || dma_ready !== 1'b0) begin errors++; $display("FAIL dmawr_busy c%0d got g%b r%b exp g10 r0", i, grant, dma_ready); end
      if (i == 1) begin
        dma_addr = 32'h0000_FFF0; dma_wdata = 32'h0; dma_we = 0;
      end
      if (i == 4) begin
        mem_ack = 1; mem_rdata = 32'h7777_7777;
      end
      tick();
    end
    mem_ack = 0; mem_rdata = '0;
    checks++; if (dma_ready !== 1'b1 || cpu_ready !== 1'b0) begin errors++; $display("FAIL dmawr_ready got %b%b exp 01", dma_ready, cpu_ready); end
    checks++; if (dma_rdata !== exp_dma_rdata) begin errors++; $display("FAIL dmawr_rdata got %h exp %h", dma_rdata, exp_dma_rdata); end
    dma_req = 0;
    tick();
    checks++; if (dma_ready !== 1'b0 || state_out !== 2'b00) begin errors++; $display("FAIL dmawr_idle got r%b s%b exp r0 s00", dma_ready, state_out); end
  endtask

  task automatic test_tie();
    logic [1:0] exp_g2;
    logic [1:0] exp_g3;
`ifdef ARB_ROUND_ROBIN_EN
    exp_g2 = 2'b10; exp_g3 = 2'b01;
`else
    exp_g2 = 2'b01; exp_g3 = 2'b10;
`endif
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    dma_req = 1; dma_we = 0; dma_addr = 32'h30;
    tick(); // round 1: DMA was served last, CPU wins either way
    checks++; if (grant !== 2'b01 || mem_addr !== 32'h20) begin errors++; $display("FAIL tie1_grant got g%b a%h exp g01 a00000020", grant, mem_addr); end
    mem_ack = 1; mem_rdata = 32'h1111_1111;
    tick();
    mem_ack = 0;
    exp_cpu_rdata = 32'h1111_1111;
    checks++; if (cpu_ready !== 1'b1 || dma_ready !== 1'b0 || cpu_rdata !== exp_cpu_rdata) begin
      errors++; $display("FAIL tie1_done got r%b%b d%h exp r10 d%h", cpu_ready, dma_ready, cpu_rdata, exp_cpu_rdata); end
    cpu_req = 0;
    tick(); // IDLE, DMA still holding its request
    cpu_req = 1;
    tick(); // round 2
    checks++; if (grant !== exp_g2) begin errors++; $display("FAIL tie2_grant got %b exp %b", grant, exp_g2); end
    mem_ack = 1; mem_rdata = 32'h2222_2222;
    tick();
    mem_ack = 0;
    if (exp_g2 == 2'b01) exp_cpu_rdata = 32'h2222_2222; else exp_dma_rdata = 32'h2222_2222;
    checks++; if ({dma_ready, cpu_ready} !== exp_g2) begin errors++; $display("FAIL tie2_ready got %b%b exp %b", dma_ready, cpu_ready, exp_g2); end
    if (exp_g2 == 2'b01) cpu_req = 0; else dma_req = 0;
    tick(); // IDLE; the loser is still requesting
    tick();
    checks++; if (grant !== exp_g3) begin errors++; $display("FAIL tie3_grant got %b exp %b", grant, exp_g3); end
    mem_ack = 1; mem_rdata = 32'h3333_3333;
    tick();
    mem_ack = 0;
    if (exp_g3 == 2'b01) exp_cpu_rdata = 32'h3333_3333; else exp_dma_rdata = 32'h3333_3333;
    checks++; if (cpu_rdata !== exp_cpu_rdata || dma_rdata !== exp_dma_rdata) begin
      errors++; $display("FAIL tie_rdata got %h/%h exp %h/%h", cpu_rdata, dma_rdata, exp_cpu_rdata, exp_dma_rdata); end
    cpu_req = 0; dma_req = 0;
    tick();
  endtask

  task automatic test_timeout();
    int en_cycles = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    tick(); // cycle 1
    for (int i = 1; i <= TIMEOUT; i++) begin
      if (mem_en === 1'b1) en_cycles++;
      if (i == TIMEOUT) begin
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_err_early got %b exp 0", bus_err); end
      end
      tick();
    end
    checks++; if (en_cycles != TIMEOUT) begin errors++; $display("FAIL to_en_cycles got %0d exp %0d", en_cycles, TIMEOUT); end
    exp_cpu_rdata = '0;
    checks++; if (cpu_ready !== 1'b1 || mem_en !== 1'b0) begin errors++; $display("FAIL to_ready got r%b e%b exp r1 e0", cpu_ready, mem_en); end
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_bus_err got %b exp 1", bus_err); end
    checks++; if (cpu_rdata !== exp_cpu_rdata) begin errors++; $display("FAIL to_rdata got %h exp %h", cpu_rdata, exp_cpu_rdata); end
    cpu_req = 0;
    tick();
    dma_req = 1; dma_we = 0; dma_addr = 32'h200;
    tick();
    mem_ack = 1; mem_rdata = 32'h0BAD_BEEF;
    tick();
    mem_ack = 0;
    exp_dma_rdata = 32'h0BAD_BEEF;
    checks++; if (dma_ready !== 1'b1 || dma_rdata !== exp_dma_rdata) begin
      errors++; $display("FAIL to_after_good got r%b d%h exp r1 d%h", dma_ready, dma_rdata, exp_dma_rdata); end
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_err_sticky got %b exp 1", bus_err); end
    dma_req = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h44;
    tick(); // cycle 1
    tick(); // cycle 2
    checks++; if (state_out !== 2'b01) begin errors++; $display("FAIL rmid_busy got %b exp 01", state_out); end
    reset = 1;
    tick();
    checks++; if (state_out !== 2'b00 || mem_en !== 1'b0) begin errors++; $display("FAIL rmid_state got s%b e%b exp s00 e0", state_out, mem_en); end
    checks++; if (cpu_ready !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL rmid_ready_grant got r%b g%b exp r0 g00", cpu_ready, grant); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rmid_bus_err got %b exp 0", bus_err); end
    reset = 0; cpu_req = 0;
    exp_cpu_rdata = '0; exp_dma_rdata = '0;
    tick();
    checks++; if (cpu_ready !== 1'b0 || state_out !== 2'b00) begin errors++; $display("FAIL rmid_after got r%b s%b exp r0 s00", cpu_ready, state_out); end
  endtask

  task automatic test_ack_at_timeout();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h50;
    tick(); // cycle 1
    for (int i = 1; i <= TIMEOUT; i++) begin
      if (i == TIMEOUT) begin
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL ackto_en got %b exp 1", mem_en); end
        mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
      end
      tick();
    end
    mem_ack = 0;
    exp_cpu_rdata = 32'hCAFE_F00D;
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL ackto_ready got %b exp 1", cpu_ready); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL ackto_bus_err got %b exp 0", bus_err); end
    checks++; if (cpu_rdata !== exp_cpu_rdata) begin errors++; $display("FAIL ackto_rdata got %h exp %h", cpu_rdata, exp_cpu_rdata); end
    cpu_req = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write_wait();
    test_tie();
    test_timeout();
    test_reset_mid();
    test_ack_at_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
